viterbi_decision_out: RTL and testbench
=======================================

// Module: viterbi_decision_out
// PURPOSE
//  Downstream stage of the ACS lane array in the Viterbi decoder. On each frame-done pulse it:
//   - captures every lane's path metric and survivor sequence;
//   - sequentially selects the lane with the largest metric;
//   - serializes that lane's survivor bits on a valid/ready stream, oldest bit first.
//  Sits between the ACS array and the decoded-bit sink.
// PARAMETERS
//  NUM_STATES  4  number of ACS lanes / trellis states (>=2)
//  PATH_WIDTH  4  path-metric width per lane
//  SEQ_WIDTH   5  survivor length per lane = decoded bits per frame (>=2)
// PORTS
//  clk          in   1                      rising-edge clock
//  reset        in   1                      asynchronous, active-low reset
//  pm_bus       in   NUM_STATES*PATH_WIDTH  lane i metric at [i*PATH_WIDTH +: PATH_WIDTH]
//  seq_bus      in   NUM_STATES*SEQ_WIDTH   lane i survivor at [i*SEQ_WIDTH +: SEQ_WIDTH]; MSB oldest
//  frame_done   in   1                      1-cycle pulse: buses hold a complete frame
//  out_ready    in   1                      sink accepts dec_bit this cycle
//  overrun_clr  in   1                      synchronous clear of overrun
//  dec_bit      out  1                      decoded bit
//  dec_valid    out  1                      dec_bit valid
//  dec_last     out  1                      final bit of frame (qualified by dec_valid)
//  busy         out  1                      high in SELECT or SHIFT
//  overrun      out  1                      sticky: frame_done arrived while busy
// BEHAVIOUR
//  Reset (reset=0, async):
//   - all outputs 0; FSM=IDLE; capture regs, best_idx, best_pm and bit counter cleared.
//  FSM states: IDLE, SELECT, SHIFT.
//  IDLE:
//   - frame_done=1 at an edge captures pm_bus and seq_bus into local registers.
//   - Same edge: best_idx=0, best_pm=pm[0], scan idx=1, go to SELECT.
//  SELECT:
//   - One lane compared per cycle (idx 1..NUM_STATES-1).
//   - Replace best only if pm[idx] > best_pm (unsigned, strict) -> ties keep the lowest index.
//   - At the edge after idx=NUM_STATES-1: load seq[best_idx] into the shift register, go to SHIFT, dec_valid=1.
//  Latency:
//   - dec_valid rises NUM_STATES edges after the edge that sampled frame_done.
//   - For the defaults this is 4 cycles.
//  SHIFT:
//   - dec_bit = shift-register MSB.
//   - On dec_valid&&out_ready: shift left, count++.
//   - dec_last=1 while count==SEQ_WIDTH-1.
//   - dec_valid/dec_bit are held stable while out_ready=0 (no bit dropped, no bit repeated).
//   - Handshake on the last bit -> IDLE, dec_valid=0 on the next cycle.
//  Back-to-back frames:
//   - frame_done on the same edge as the last-bit handshake is accepted: capture, go directly to SELECT.
//  Overrun:
//   - frame_done at any other time in SELECT/SHIFT sets overrun and discards that frame.
//   - The current frame continues unaffected.
//  Clearing overrun:
//   - overrun_clr=1 clears overrun.
//   - If overrun_clr and a new overrun occur on the same edge, set wins.
//  Capture isolation:
//   - pm_bus/seq_bus are ignored outside capture edges.
//   - The ACS may update freely during SELECT/SHIFT.
//  Reset mid-frame: the frame is abandoned immediately; no partial output after reset release.
// CONFIGURATION
//  PM_REPORT_EN defined:
//   - adds output best_pm_out [PATH_WIDTH], reset 0.
//   - Loaded with the winning metric on the SELECT->SHIFT edge; held until the next frame's load.
//  PM_REPORT_EN undefined:
//   - port and register absent; all other behaviour identical.
// TESTING  (defaults NUM_STATES=4, PATH_WIDTH=4, SEQ_WIDTH=5)
//  1 Basic:
//   - Stimulus: pm={s0:3,s1:9,s2:7,s3:2}, seq[s1]=5'b10110, out_ready=1, frame_done pulse.
//   - Required: dec_valid rises after 4 cycles; bits 1,0,1,1,0 on consecutive cycles; dec_last on the 5th only; busy drops after.
//  2 Tie:
//   - Stimulus: all pm=6, seq[s0]=5'b00001, seq[s2]=5'b11111.
//   - Required: output 0,0,0,0,1 (lane 0 wins).
//  3 Backpressure:
//   - Stimulus: case 1 with out_ready toggled 1,0,0,1,...
//   - Required: each bit held while out_ready=0; same 5-bit order; exactly 5 handshakes.
//  4 Overrun:
//   - Stimulus: frame_done during SELECT.
//   - Required: overrun=1, output still the first frame only.
//   - Stimulus: overrun_clr pulse.
//   - Required: overrun=0.
//   - Stimulus: frame_done on the last handshake edge.
//   - Required: accepted, second frame emitted with no overrun.
//  5 Reset mid-SHIFT:
//   - Stimulus: reset low after 2 bits.
//   - Required: dec_valid, busy and overrun go 0 immediately; after release, nothing is emitted until a new frame_done.
//  6 PM_REPORT_EN:
//   - Stimulus: case 1.
//   - Required: best_pm_out=9 from the SHIFT entry edge; stays 9 until the next frame's load.

Source files
------------

// File: rtl/viterbi_decision_out_if.sv
// Stream interface between the ACS lane array, the decision/output stage and the decoded-bit sink.
// Optional best_pm_out signal is present only when PM_REPORT_EN is defined.
interface viterbi_decision_out_if #(
    parameter int NUM_STATES = 4,
    parameter int PATH_WIDTH = 4,
    parameter int SEQ_WIDTH  = 5
);
    logic [NUM_STATES*PATH_WIDTH-1:0] pm_bus;
    logic [NUM_STATES*SEQ_WIDTH-1:0]  seq_bus;
    logic                             frame_done;
    logic                             out_ready;
    logic                             overrun_clr;
    logic                             dec_bit;
    logic                             dec_valid;
    logic                             dec_last;
    logic                             busy;
    logic                             overrun;
`ifdef PM_REPORT_EN
    logic [PATH_WIDTH-1:0]            best_pm_out;
`endif

    // Master is the ACS/sink side; slave is the decision stage.
    modport master (
`ifdef PM_REPORT_EN
        input  best_pm_out,
`endif
        output pm_bus, seq_bus, frame_done, out_ready, overrun_clr,
        input  dec_bit, dec_valid, dec_last, busy, overrun
    );

    modport slave (
`ifdef PM_REPORT_EN
        output best_pm_out,
`endif
        input  pm_bus, seq_bus, frame_done, out_ready, overrun_clr,
        output dec_bit, dec_valid, dec_last, busy, overrun
    );
endinterface

// File: rtl/viterbi_decision_out.sv
// Viterbi decision stage: captures all lanes on frame_done, picks the max-metric lane one lane per cycle,
// then streams its survivor MSB-first. Define PM_REPORT_EN to expose the winning metric on best_pm_out.
module viterbi_decision_out #(
    parameter int NUM_STATES = 4,
    parameter int PATH_WIDTH = 4,
    parameter int SEQ_WIDTH  = 5
) (
    input logic                  clk,
    input logic                  reset,
    viterbi_decision_out_if.slave bus
);
    localparam int IDX_W  = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam int SCAN_W = $clog2(NUM_STATES + 1);
    localparam int CNT_W  = (SEQ_WIDTH > 1) ? $clog2(SEQ_WIDTH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;

    logic [1:0]            state;
    logic [PATH_WIDTH-1:0] pm_cap  [NUM_STATES];
    logic [SEQ_WIDTH-1:0]  seq_cap [NUM_STATES];
    logic [IDX_W-1:0]      best_idx;
    logic [PATH_WIDTH-1:0] best_pm;
    logic [SCAN_W-1:0]     scan_idx;
    logic [SEQ_WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]      count;
    logic                  overrun_q;
`ifdef PM_REPORT_EN
    logic [PATH_WIDTH-1:0] best_pm_q;
`endif

    logic             handshake;
    logic             last_bit;
    logic             capture;
    logic             scan_done;
    logic [IDX_W-1:0] scan_lane;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        handshake = (state == S_SHIFT) && bus.out_ready;
        last_bit  = (count == CNT_W'(SEQ_WIDTH - 1));
        // A frame is taken when idle, or on the very edge that hands off the last bit.
        capture   = bus.frame_done && ((state == S_IDLE) || (handshake && last_bit));
        scan_done = (scan_idx == SCAN_W'(NUM_STATES));
        scan_lane = scan_idx[IDX_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            best_idx <= '0;
            best_pm  <= '0;
            scan_idx <= '0;
            shreg    <= '0;
            count    <= '0;
            // NOTE: the capture arrays are small and must read as zero after reset, so they are reset too.
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_cap[i]  <= '0;
                seq_cap[i] <= '0;
            end
`ifdef PM_REPORT_EN
            best_pm_q <= '0;
`endif
        end else if (capture) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_cap[i]  <= bus.pm_bus[i*PATH_WIDTH +: PATH_WIDTH];
                seq_cap[i] <= bus.seq_bus[i*SEQ_WIDTH +: SEQ_WIDTH];
            end
            best_idx <= '0;
            best_pm  <= bus.pm_bus[PATH_WIDTH-1:0];
            scan_idx <= SCAN_W'(1);
            state    <= S_SELECT;
        end else begin
            case (state)
                S_SELECT: begin
                    if (scan_done) begin
                        shreg <= seq_cap[best_idx];
                        count <= '0;
                        state <= S_SHIFT;
`ifdef PM_REPORT_EN
                        best_pm_q <= best_pm;
`endif
                    end else begin
                        // Strictly greater: ties keep the lower lane index.
                        if (pm_cap[scan_lane] > best_pm) begin
                            best_idx <= scan_lane;
                            best_pm  <= pm_cap[scan_lane];
                        end
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (handshake) begin
                        shreg <= shreg << 1;
                        count <= count + 1'b1;
                        if (last_bit) state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // A frame_done that is not accepted while busy is dropped; a new overrun beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (bus.frame_done && (state != S_IDLE) && !capture) begin
            overrun_q <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.dec_valid = (state == S_SHIFT);
    assign bus.dec_bit   = bus.dec_valid && shreg[SEQ_WIDTH-1];
    assign bus.dec_last  = bus.dec_valid && last_bit;
    assign bus.busy      = (state != S_IDLE);
    assign bus.overrun   = overrun_q;
`ifdef PM_REPORT_EN
    assign bus.best_pm_out = best_pm_q;
`endif
endmodule

// File: tb/tb_viterbi_decision_out.sv
// Directed testbench for viterbi_decision_out: table of single frames plus hand-written
// backpressure, overrun, back-to-back and mid-frame reset sequences.
module tb_viterbi_decision_out;
    localparam int NS = 4;
    localparam int PW = 4;
    localparam int SW = 5;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    viterbi_decision_out_if #(.NUM_STATES(NS), .PATH_WIDTH(PW), .SEQ_WIDTH(SW)) bus ();

    viterbi_decision_out #(.NUM_STATES(NS), .PATH_WIDTH(PW), .SEQ_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NS*PW-1:0] pm;
        logic [NS*SW-1:0] seq;
        logic [SW-1:0]    exp_bits;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; returns 1 time unit after the capture edge with scrambled buses.
    task automatic pulse_frame(input logic [NS*PW-1:0] pm, input logic [NS*SW-1:0] seq);
        bus.pm_bus     = pm;
        bus.seq_bus    = seq;
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        bus.pm_bus     = ~pm;
        bus.seq_bus    = ~seq;
    endtask

    // Wait for dec_valid (expected after exp_lat more edges), then check all bits with out_ready=1.
    task automatic expect_stream(input string name, input logic [SW-1:0] exp, input int exp_lat);
        int lat = 0;
        bus.out_ready = 1'b1;
        while (!bus.dec_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        for (int k = 0; k < SW; k++) begin
            check($sformatf("%s bit%0d", name, k), bus.dec_bit, exp[SW-1-k]);
            check($sformatf("%s last%0d", name, k), bus.dec_last, (k == SW-1));
            step();
        end
        check({name, " valid_after"}, bus.dec_valid, 1'b0);
        check({name, " busy_after"}, bus.busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{16'h2793, {5'b00111, 5'b11100, 5'b10110, 5'b01010}, 5'b10110};
        vecs[1] = '{16'h6666, {5'b10101, 5'b11111, 5'b01110, 5'b00001}, 5'b00001};
        vecs[2] = '{16'hFE0E, {5'b11001, 5'b01011, 5'b10000, 5'b00110}, 5'b11001};
        vecs[3] = '{16'h0000, {5'b00000, 5'b11111, 5'b01100, 5'b10011}, 5'b10011};
        vecs[4] = '{16'h8187, {5'b10010, 5'b11111, 5'b01101, 5'b00000}, 5'b01101};

        reset           = 1'b0;
        bus.pm_bus      = '0;
        bus.seq_bus     = '0;
        bus.frame_done  = 1'b0;
        bus.out_ready   = 1'b1;
        bus.overrun_clr = 1'b0;
        #12;
        check("reset dec_valid", bus.dec_valid, 1'b0);
        check("reset dec_bit", bus.dec_bit, 1'b0);
        check("reset dec_last", bus.dec_last, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset overrun", bus.overrun, 1'b0);
`ifdef PM_REPORT_EN
        check("reset best_pm_out", bus.best_pm_out, 4'd0);
`endif
        reset = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            pulse_frame(vecs[i].pm, vecs[i].seq);
            check($sformatf("vec%0d busy", i), bus.busy, 1'b1);
            check($sformatf("vec%0d early_valid", i), bus.dec_valid, 1'b0);
            expect_stream($sformatf("vec%0d", i), vecs[i].exp_bits, NS);
            step();
        end

        // Backpressure: out_ready repeats 1,0,0,1; stalled bits must hold.
        begin
            logic [SW-1:0] got = '0;
            int   hs = 0;
            logic prev_stall = 1'b0;
            logic prev_bit   = 1'b0;
            int   hold_err = 0;
            logic [3:0] pat = 4'b1001;
            pulse_frame(vecs[0].pm, vecs[0].seq);
            for (int c = 0; c < 40; c++) begin
                bus.out_ready = pat[3 - (c % 4)];
                if (prev_stall && (!bus.dec_valid || bus.dec_bit !== prev_bit)) hold_err++;
                if (bus.dec_valid && bus.out_ready) begin
                    if (hs < SW) got[SW-1-hs] = bus.dec_bit;
                    hs++;
                end
                prev_stall = bus.dec_valid && !bus.out_ready;
                prev_bit   = bus.dec_bit;
                step();
            end
            check("bp bits", got, vecs[0].exp_bits);
            check("bp handshakes", hs, SW);
            check("bp hold", hold_err, 0);
            check("bp busy_after", bus.busy, 1'b0);
            bus.out_ready = 1'b1;
        end

        // Overrun during SELECT: second frame dropped, first frame output unchanged.
        pulse_frame(vecs[0].pm, vecs[0].seq);
        step();
        pulse_frame(vecs[2].pm, vecs[2].seq);
        check("ovr set", bus.overrun, 1'b1);
        expect_stream("ovr stream", vecs[0].exp_bits, NS - 2);
        check("ovr sticky", bus.overrun, 1'b1);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        check("ovr clr", bus.overrun, 1'b0);

        // Clear and new overrun on the same edge: set wins.
        pulse_frame(vecs[1].pm, vecs[1].seq);
        bus.overrun_clr = 1'b1;
        pulse_frame(vecs[2].pm, vecs[2].seq);
        bus.overrun_clr = 1'b0;
        check("ovr set_wins", bus.overrun, 1'b1);
        expect_stream("ovr sw stream", vecs[1].exp_bits, NS - 1);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;

        // Back-to-back: frame_done on the last handshake edge is accepted.
        begin
            int guard = 0;
            pulse_frame(vecs[0].pm, vecs[0].seq);
            while (!(bus.dec_valid && bus.dec_last) && guard < 30) begin
                step();
                guard++;
            end
            check("b2b reached_last", bus.dec_last, 1'b1);
            pulse_frame(vecs[2].pm, vecs[2].seq);
            check("b2b no_overrun", bus.overrun, 1'b0);
            check("b2b busy", bus.busy, 1'b1);
            check("b2b gap", bus.dec_valid, 1'b0);
            expect_stream("b2b stream", vecs[2].exp_bits, NS);
            check("b2b overrun_end", bus.overrun, 1'b0);
        end

        // Reset mid-SHIFT after two bits, with an overrun pending.
        begin
            int guard = 0;
            int stray = 0;
            pulse_frame(vecs[0].pm, vecs[0].seq);
            while (!bus.dec_valid && guard < 20) begin
                step();
                guard++;
            end
            bus.frame_done = 1'b1;
            step();
            bus.frame_done = 1'b0;
            step();
            check("rst pre_overrun", bus.overrun, 1'b1);
            check("rst pre_valid", bus.dec_valid, 1'b1);
            #2;
            reset = 1'b0;
            #1;
            check("rst dec_valid", bus.dec_valid, 1'b0);
            check("rst busy", bus.busy, 1'b0);
            check("rst overrun", bus.overrun, 1'b0);
            @(negedge clk);
            reset = 1'b1;
            for (int c = 0; c < 12; c++) begin
                step();
                if (bus.dec_valid || bus.busy) stray++;
            end
            check("rst no_output", stray, 0);
            pulse_frame(vecs[4].pm, vecs[4].seq);
            expect_stream("rst recover", vecs[4].exp_bits, NS);
        end

`ifdef PM_REPORT_EN
        // Winning metric is loaded on SHIFT entry and held until the next frame's load.
        pulse_frame(vecs[0].pm, vecs[0].seq);
        expect_stream("pm basic", vecs[0].exp_bits, NS);
        check("pm after basic", bus.best_pm_out, 4'd9);
        pulse_frame(vecs[1].pm, vecs[1].seq);
        step();
        check("pm held in select", bus.best_pm_out, 4'd9);
        expect_stream("pm tie", vecs[1].exp_bits, NS - 1);
        check("pm after tie", bus.best_pm_out, 4'd6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
